// File: rtl/pl_stage_buf.sv
// rtl/pl_stage_buf.sv - elastic pipeline-stage register with 2-entry skid buffer, flush and stall counter
module pl_stage_buf #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   main_q, main_d;
  logic [WIDTH-1:0]   skid_q, skid_d;
  logic [CNT_W-1:0]   stall_q;
  logic               accept;
  logic               consume;

  // Handshakes decode from registered state only, so out_ready never reaches in_ready combinationally.
  always_comb begin
    in_ready  = (state_q != FULL);
    out_valid = (state_q != EMPTY);
    case (state_q)
      ONE:     occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  assign accept       = in_valid & in_ready;
  assign consume      = out_valid & out_ready;
  assign out_data     = main_q;
  assign stall_cycles = stall_q;

  // Next-state and storage update; flush overrides everything and leaves a bubble in main.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d             = EMPTY;
      main_d[CTRL_W-1:0]  = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_d  = in_data;
            state_d = ONE;
          end
        end
        ONE: begin
          if (accept && consume) begin
            main_d = in_data;
          end else if (accept) begin
            skid_d  = in_data;
            state_d = FULL;
          end else if (consume) begin
            main_d[CTRL_W-1:0] = '0;
            state_d            = EMPTY;
          end
        end
        FULL: begin
          if (consume) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: begin
          main_d[CTRL_W-1:0] = '0;
          state_d            = EMPTY;
        end
      endcase
    end
  end

  // State and payload registers; reset empties the stage and clears both payload registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Saturating count of cycles where a valid output is held back; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pl_stage_buf.sv
// tb/tb_pl_stage_buf.sv - self-checking bench for pl_stage_buf
module tb_pl_stage_buf;

  localparam int WIDTH  = 32;
  localparam int CTRL_W = 8;
  localparam int CNT_W  = 4;
  localparam int SAT    = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] stall_cycles;

  int total;
  int bad;

  logic [WIDTH-1:0] mq[$];
  int               mstall;

  typedef struct {
    logic        fl;
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        ev;
    logic [1:0]  eocc;
    logic        erdy;
    logic [31:0] edata;
    logic [3:0]  estall;
  } vec_t;

  vec_t tbl[14];

  pl_stage_buf #(.WIDTH(WIDTH), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .occupancy    (occupancy),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: the stage is a FIFO of at most two entries seen only through its head.
  task automatic model_cycle(input logic fl, input logic iv, input logic [31:0] d, input logic ordy);
    int n;
    n = mq.size();
    if (n > 0 && !ordy && mstall < SAT) mstall++;
    if (fl) begin
      mq.delete();
    end else begin
      if (n > 0 && ordy) void'(mq.pop_front());
      if (iv && n < 2) mq.push_back(d);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'(mq.size() > 0));
    chk({tag, "_occ"},   32'(occupancy), 32'(mq.size()));
    chk({tag, "_ready"}, 32'(in_ready),  32'(mq.size() < 2));
    chk({tag, "_stall"}, 32'(stall_cycles), 32'(mstall));
    if (mq.size() > 0) chk({tag, "_data"}, out_data, mq[0]);
    else               chk({tag, "_bubble"}, 32'(out_data[CTRL_W-1:0]), 32'd0);
  endtask

  task automatic drive(input logic fl, input logic iv, input logic [31:0] d, input logic ordy);
    flush     = fl;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    model_cycle(fl, iv, d, ordy);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    rst_n = 1'b0;
    mq.delete();
    mstall = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] mask;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    do_reset();

    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_occ",   32'(occupancy), 32'd0);
    chk("rst_data",  out_data, 32'd0);
    chk("rst_stall", 32'(stall_cycles), 32'd0);

    //          fl    iv    d              ordy  ev    occ   rdy   data           stall
    tbl[0]  = '{1'b0, 1'b1, 32'h0000000A, 1'b1, 1'b1, 2'd1, 1'b1, 32'h0000000A, 4'd0};
    tbl[1]  = '{1'b0, 1'b1, 32'h0000000B, 1'b0, 1'b1, 2'd2, 1'b0, 32'h0000000A, 4'd1};
    tbl[2]  = '{1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1, 2'd2, 1'b0, 32'h0000000A, 4'd2};
    tbl[3]  = '{1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 2'd1, 1'b1, 32'h0000000B, 4'd2};
    tbl[4]  = '{1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 2'd0, 1'b1, 32'h00000000, 4'd2};
    tbl[5]  = '{1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 2'd1, 1'b1, 32'hDEADBEEF, 4'd2};
    tbl[6]  = '{1'b0, 1'b1, 32'h12345678, 1'b0, 1'b1, 2'd2, 1'b0, 32'hDEADBEEF, 4'd3};
    tbl[7]  = '{1'b1, 1'b1, 32'h00000055, 1'b1, 1'b0, 2'd0, 1'b1, 32'h00000000, 4'd3};
    tbl[8]  = '{1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 2'd0, 1'b1, 32'h00000000, 4'd3};
    tbl[9]  = '{1'b0, 1'b1, 32'h000000FF, 1'b0, 1'b1, 2'd1, 1'b1, 32'h000000FF, 4'd3};
    tbl[10] = '{1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 2'd0, 1'b1, 32'h00000000, 4'd3};
    tbl[11] = '{1'b0, 1'b1, 32'hCAFE0001, 1'b1, 1'b1, 2'd1, 1'b1, 32'hCAFE0001, 4'd3};
    tbl[12] = '{1'b0, 1'b1, 32'h00000002, 1'b1, 1'b1, 2'd1, 1'b1, 32'h00000002, 4'd3};
    tbl[13] = '{1'b1, 1'b0, 32'h00000000, 1'b0, 1'b0, 2'd0, 1'b1, 32'h00000000, 4'd4};

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].fl, tbl[i].iv, tbl[i].d, tbl[i].ordy);
      mask = tbl[i].ev ? 32'hFFFFFFFF : 32'h000000FF;
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
      chk($sformatf("vec%0d_occ", i),   32'(occupancy), 32'(tbl[i].eocc));
      chk($sformatf("vec%0d_ready", i), 32'(in_ready),  32'(tbl[i].erdy));
      chk($sformatf("vec%0d_data", i),  out_data & mask, tbl[i].edata);
      chk($sformatf("vec%0d_stall", i), 32'(stall_cycles), 32'(tbl[i].estall));
    end

    // Reset asserted mid-cycle while FULL takes effect without waiting for a clock edge.
    drive(1'b0, 1'b1, 32'h000000AA, 1'b0);
    drive(1'b0, 1'b1, 32'h000000BB, 1'b0);
    chk("pre_rst_occ", 32'(occupancy), 32'd2);
    in_valid = 1'b0; out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_occ",   32'(occupancy), 32'd0);
    chk("async_rst_ready", 32'(in_ready), 32'd1);
    chk("async_rst_data",  out_data, 32'd0);
    chk("async_rst_stall", 32'(stall_cycles), 32'd0);
    do_reset();

    // Streaming at full throughput with one-cycle latency.
    for (int i = 1; i <= 16; i++) begin
      drive(1'b0, 1'b1, 32'(i), 1'b1);
      chk($sformatf("stream%0d_data", i),  out_data, 32'(i));
      chk($sformatf("stream%0d_occ", i),   32'(occupancy), 32'd1);
      chk($sformatf("stream%0d_stall", i), 32'(stall_cycles), 32'd0);
    end
    drive(1'b0, 1'b0, 32'd0, 1'b1);
    chk("drain_valid", 32'(out_valid), 32'd0);

    // Stall counter saturation, and flush leaving the count untouched.
    drive(1'b0, 1'b1, 32'h00000077, 1'b0);
    for (int i = 0; i < 20; i++) drive(1'b0, 1'b0, 32'd0, 1'b0);
    chk("sat_stall", 32'(stall_cycles), 32'(SAT));
    chk("sat_data",  out_data, 32'h00000077);
    drive(1'b1, 1'b0, 32'd0, 1'b0);
    chk("sat_flush_stall", 32'(stall_cycles), 32'(SAT));
    chk("sat_flush_occ",   32'(occupancy), 32'd0);
    check_model("sat_model");

    // Randomised traffic against the FIFO reference.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      drive(($urandom_range(15) == 0), ($urandom_range(1) == 1), $urandom(),
            ($urandom_range(9) < 6));
      check_model("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
